mt_seeder: RTL and testbench
============================

MT_SEEDER -- requirements
Module: mt_seeder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to generate a full initial state from seed.
REQ-004 SHALL have port seed, input, 32, seed value, sampled only on the accepted start.
REQ-005 SHALL have port load_ready, input, 1, downstream mersenne_twister can take a word this cycle.
REQ-006 SHALL have port load_value, output, 1, value is valid; a transfer occurs when load_value && load_ready.
REQ-007 SHALL have port value, output, 32, current state word x[i].
REQ-008 SHALL have port index, output, 10, index i (0..623) of the word on value.
REQ-009 SHALL have port busy, output, 1, high from the accepted start until the final transfer.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after the 624th transfer.

Function
REQ-011 SHALL generate x[0]=seed and x[i]=(1812433253*(x[i-1]^(x[i-1]>>30))+i) mod 2^32 for i=1..623.
REQ-012 SHALL use FSM states IDLE, EMIT, FINISH (plus CALC when MT_SEEDER_PIPE_EN is defined).
REQ-013 SHALL, in IDLE with start=1 at edge k, latch seed and enter EMIT; load_value=1, value=seed, index=0 after edge k.
REQ-014 SHALL ignore start while busy=1.
REQ-015 SHALL hold value, index and load_value=1 stable while load_value=1 and load_ready=0.
REQ-016 SHALL, without the macro, present x[i+1] in the cycle after the transfer of x[i] (1 word/cycle at full ready).
REQ-017 SHALL, on the transfer of index 623, go to FINISH: load_value=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-018 SHALL accept a start in the cycle after done, so a new generation begins.
REQ-019 SHALL compute all arithmetic at 32 bits, with the low 32 product bits kept; index+1 zero-extended to 32 for the add.
REQ-020 SHALL tolerate load_ready toggling every cycle without losing or repeating words.

Reset
REQ-021 SHALL, with rst=1 at any edge including mid-generation, return to IDLE with load_value=0, busy=0, done=0, index=0, value=0.
REQ-022 SHALL, on rst and start high together, give rst priority.

Configuration
REQ-023 SHALL use the macro MT_SEEDER_PIPE_EN to register the multiplier output (state CALC).
REQ-024 SHALL, with MT_SEEDER_PIPE_EN defined, add one cycle between transfer of x[i] and presentation of x[i+1]: at most 1 word per 2 cycles; output values unchanged.
REQ-025 SHALL, with MT_SEEDER_PIPE_EN undefined, contain no CALC state and use the single-cycle path of REQ-016.

Structure
REQ-026 SHALL take from shared package mt_pkg: MT_N=624, MT_INIT_MULT=32'd1812433253, MT_DEFAULT_SEED=32'd5489, and the seeder state enum type.
REQ-027 SHALL implement the next-word computation (xor-shift, multiply, add index) in one combinational sub-module, mt_seed_step.

Verification
REQ-028 SHALL test seed=5489, load_ready=1 -> words 0,1 = 5489, 1301868182; exactly 624 transfers; done one cycle after the 624th.
REQ-029 SHALL test seed=0 -> x[0]=0, x[1]=1, x[2]=1812433255; no macro: 624 transfers in 624 consecutive cycles.
REQ-030 SHALL test load_ready low for 5 cycles at index 100 -> value/index held constant; sequence identical to the full-ready run.
REQ-031 SHALL test rst=1 at index 300 -> next cycle load_value=0, busy=0, index=0; a new start with seed=5489 regenerates from x[0]=5489.
REQ-032 SHALL test start pulsed at index 50 with seed=1 -> ignored; output remains the seed=5489 sequence.
REQ-033 SHALL test MT_SEEDER_PIPE_EN defined, load_ready=1 -> same 624 values, one transfer every 2 cycles, done at cycle ~1248.

Source files
------------

// File: rtl/mt_pkg.sv
// Shared definitions for the Mersenne Twister seeder.
// Holds the state-array length, the initialisation multiplier, the default seed
// and the seeder FSM state type.
// Build option: MT_SEEDER_PIPE_EN adds the StCalc state, which holds the
// registered step result for one cycle.
package mt_pkg;

  localparam int unsigned MT_N            = 624;
  localparam logic [31:0] MT_INIT_MULT    = 32'd1812433253;
  localparam logic [31:0] MT_DEFAULT_SEED = 32'd5489;

`ifdef MT_SEEDER_PIPE_EN
  typedef enum logic [1:0] {StIdle, StEmit, StCalc, StFinish} seeder_state_e;
`else
  typedef enum logic [1:0] {StIdle, StEmit, StFinish} seeder_state_e;
`endif

endpackage

// File: rtl/mt_seed_step.sv
// One step of the MT19937 initialisation recurrence, purely combinational.
//   x_prev : previous state word x[i-1]
//   idx    : index i of the word being produced
//   x_next : (MT_INIT_MULT * (x_prev ^ (x_prev >> 30)) + i) mod 2^32
module mt_seed_step
  import mt_pkg::*;
(
  input  logic [31:0] x_prev,
  input  logic [9:0]  idx,
  output logic [31:0] x_next
);

  logic [31:0] mixed;
  logic [31:0] product;

  always_comb begin
    mixed   = x_prev ^ (x_prev >> 30);
    // 32x32 multiply in a 32-bit context keeps only the low product bits.
    product = MT_INIT_MULT * mixed;
    x_next  = product + {22'd0, idx};
  end

endmodule

// File: rtl/mt_seeder.sv
// Generates the 624-word MT19937 initial state from a 32-bit seed and streams
// it to a downstream twister over a valid/ready handshake.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, seed   : start a generation; seed is captured when start is accepted
//   load_ready    : downstream can take a word this cycle
//   load_value    : value/index are valid (transfer on load_value && load_ready)
//   value, index  : current state word x[index]
//   busy          : generation in progress
//   done          : one-cycle pulse after the last transfer
// Build option: MT_SEEDER_PIPE_EN registers the step result and inserts the
// StCalc state, giving at most one word every two cycles.
module mt_seeder
  import mt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic        load_ready,
  output logic        load_value,
  output logic [31:0] value,
  output logic [9:0]  index,
  output logic        busy,
  output logic        done
);

  seeder_state_e state_q, state_d;
  logic [31:0]   value_q, value_d;
  logic [9:0]    index_q, index_d;
  logic [9:0]    index_inc;
  logic [31:0]   step_next;
  logic          last_word;

  assign index_inc = index_q + 10'd1;
  assign last_word = (index_q == 10'(MT_N - 1));

  mt_seed_step u_step (
    .x_prev (value_q),
    .idx    (index_inc),
    .x_next (step_next)
  );

`ifdef MT_SEEDER_PIPE_EN
  logic [31:0] next_q;

  // Step result captured on each transfer, presented from StCalc.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_q <= '0;
    end else if (state_q == StEmit && load_ready) begin
      next_q <= step_next;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      value_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      index_q <= index_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    index_d = index_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          value_d = seed;
          index_d = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (load_ready) begin
          if (last_word) begin
            state_d = StFinish;
          end else begin
            index_d = index_inc;
`ifdef MT_SEEDER_PIPE_EN
            state_d = StCalc;
`else
            value_d = step_next;
`endif
          end
        end
      end
`ifdef MT_SEEDER_PIPE_EN
      StCalc: begin
        value_d = next_q;
        state_d = StEmit;
      end
`endif
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    load_value = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StEmit: begin
        load_value = 1'b1;
        busy       = 1'b1;
      end
`ifdef MT_SEEDER_PIPE_EN
      StCalc: busy = 1'b1;
`endif
      StFinish: done = 1'b1;
      default: ;
    endcase
  end

  assign value = value_q;
  assign index = index_q;

endmodule

// File: tb/tb_mt_seeder.sv
module tb_mt_seeder;
  import mt_pkg::*;

  logic        tb_clk;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic        load_ready;
  logic        load_value;
  logic [31:0] value;
  logic [9:0]  index;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_w [624];

  mt_seeder dut (
    .clk        (tb_clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .load_ready (load_ready),
    .load_value (load_value),
    .value      (value),
    .index      (index),
    .busy       (busy),
    .done       (done)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Reference sequence from the recurrence, using wide integer arithmetic.
  task automatic build_model(input logic [31:0] s);
    longint unsigned x;
    x = longint'(s);
    exp_w[0] = s;
    for (int i = 1; i < 624; i++) begin
      x = (64'd1812433253 * (x ^ (x >> 30)) + longint'(i)) % 64'h1_0000_0000;
      exp_w[i] = x[31:0];
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // mode: 0 full ready, 1 random ready, 2 five-cycle stall at index 100,
  //       3 reset at index 300, 4 ignored start at index 50
  task automatic run_gen(input logic [31:0] s, input int mode);
    int  n;
    int  cyc;
    int  stall;
    bit  xfer;
    bit  lv_exp;
    build_model(s);
    start = 1'b1;
    seed  = s;
    load_ready = 1'b1;
    step();
    start = 1'b0;
    seed  = $urandom;
    check_eq("start_load_value", 32'(load_value), 32'd1);
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_index", 32'(index), 32'd0);
    check_eq("start_value", value, s);
    n = 0;
    cyc = 0;
    stall = 0;
    while (n < 624 && cyc < 5000) begin
      if (mode == 3 && n == 300 && load_value) begin
        check_eq("pre_rst_index", 32'(index), 32'd300);
        rst   = 1'b1;
        start = 1'b1;
        seed  = 32'd1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_load_value", 32'(load_value), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_index", 32'(index), 32'd0);
        check_eq("rst_value", value, 32'd0);
        step();
        check_eq("rst_prio_load_value", 32'(load_value), 32'd0);
        check_eq("rst_prio_busy", 32'(busy), 32'd0);
        return;
      end
      case (mode)
        1: load_ready = 1'($urandom_range(0, 1));
        2: begin
          if (n == 100 && load_value && stall < 5) begin
            load_ready = 1'b0;
            stall++;
          end else begin
            load_ready = 1'b1;
          end
        end
        default: load_ready = 1'b1;
      endcase
      if (mode == 4 && n == 50 && load_value) begin
        start = 1'b1;
        seed  = 32'd1;
      end else begin
        start = 1'b0;
      end
      check_eq("busy_during_gen", 32'(busy), 32'd1);
      check_eq("done_during_gen", 32'(done), 32'd0);
      if (mode == 0) begin
`ifdef MT_SEEDER_PIPE_EN
        lv_exp = (cyc % 2 == 0);
`else
        lv_exp = 1'b1;
`endif
        check_eq("rate_load_value", 32'(load_value), 32'(lv_exp));
      end
      if (load_value) begin
        check_eq("word_index", 32'(index), 32'(n));
        check_eq("word_value", value, exp_w[n]);
        if (s == 32'd5489 && n == 1) check_eq("known_5489_w1", value, 32'd1301868182);
        if (s == 32'd0 && n == 1) check_eq("known_0_w1", value, 32'd1);
        if (s == 32'd0 && n == 2) check_eq("known_0_w2", value, 32'd1812433255);
      end
      xfer = load_value && load_ready;
      step();
      cyc++;
      if (xfer) n++;
    end
    start = 1'b0;
    check_eq("transfer_count", 32'(n), 32'd624);
    check_eq("fin_done", 32'(done), 32'd1);
    check_eq("fin_busy", 32'(busy), 32'd0);
    check_eq("fin_load_value", 32'(load_value), 32'd0);
    if (mode == 0) begin
`ifdef MT_SEEDER_PIPE_EN
      check_eq("cycles_to_done", 32'(cyc), 32'd1247);
`else
      check_eq("cycles_to_done", 32'(cyc), 32'd624);
`endif
    end
    step();
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_load_value", 32'(load_value), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    seed       = '0;
    load_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("reset_load_value", 32'(load_value), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_index", 32'(index), 32'd0);
    check_eq("reset_value", value, 32'd0);
    step();
    check_eq("idle_no_start", 32'(load_value), 32'd0);

    run_gen(MT_DEFAULT_SEED, 0);
    run_gen(32'd0, 0);
    run_gen(MT_DEFAULT_SEED, 2);
    run_gen(MT_DEFAULT_SEED, 1);
    run_gen(MT_DEFAULT_SEED, 3);
    run_gen(MT_DEFAULT_SEED, 0);
    run_gen(MT_DEFAULT_SEED, 4);
    run_gen($urandom, 1);
    run_gen($urandom, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
